// File: rtl/csr_lane_dispatcher_if.sv
// ---------------------------------------------------------------------------
// csr_lane_dispatcher_if
//
// Purpose:
//   Groups the data-RAM read port and the per-lane valid/ready output
//   handshake of csr_lane_dispatcher into one bundle.
//
// Signals:
//   mem_addr    dispatcher -> RAM    read address
//   mem_ce      dispatcher -> RAM    read enable
//   mem_q       RAM -> dispatcher    {col, value}, valid one cycle after mem_ce
//   lane_valid  dispatcher -> lanes  one-hot (or zero) valid per lane
//   lane_ready  lanes -> dispatcher  per-lane accept
//   lane_data   dispatcher -> lanes  {row, col, value}, shared by all lanes
//
// Modports:
//   master  the dispatcher side
//   slave   the RAM / lane side
// ---------------------------------------------------------------------------
interface csr_lane_dispatcher_if #(
  parameter int ADDR_W    = 10,
  parameter int COL_W     = 4,
  parameter int DATA_W    = 8,
  parameter int ROW_W     = 4,
  parameter int NUM_LANES = 2
);

  logic [ADDR_W-1:0]             mem_addr;
  logic                          mem_ce;
  logic [COL_W+DATA_W-1:0]       mem_q;
  logic [NUM_LANES-1:0]          lane_valid;
  logic [NUM_LANES-1:0]          lane_ready;
  logic [ROW_W+COL_W+DATA_W-1:0] lane_data;

  modport master (
    output mem_addr,
    output mem_ce,
    input  mem_q,
    output lane_valid,
    input  lane_ready,
    output lane_data
  );

  modport slave (
    input  mem_addr,
    input  mem_ce,
    output mem_q,
    input  lane_valid,
    output lane_ready,
    input  lane_data
  );

endinterface

// File: rtl/csr_lane_dispatcher.sv
// ---------------------------------------------------------------------------
// csr_lane_dispatcher
//
// Purpose:
//   Walks one CSR-compressed matrix stored in an external synchronous data
//   RAM and recovers (row, col, value) for every nonzero. Nonzeros are dealt
//   round-robin to NUM_LANES downstream lanes over a per-lane valid/ready
//   handshake. Empty rows are skipped at one cycle per row boundary; a walk
//   can be cancelled at any time with abort.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   start      begin a walk (only looked at while idle)
//   abort      synchronous cancel, returns to idle without a done pulse
//   base_addr  RAM address of nonzero 0
//   num_rows   number of rows to walk, 0..2**ROW_W
//   ptr_vec    row pointer table, entry i = nonzeros before row i;
//              must hold from start until done
//   nz_total   total nonzero count latched at start
//   busy       high whenever the walker is not idle
//   done       one-cycle pulse when a walk completes
//   bus        RAM read port and lane handshake (master modport)
// ---------------------------------------------------------------------------
module csr_lane_dispatcher #(
  parameter int DATA_W    = 8,
  parameter int COL_W     = 4,
  parameter int ROW_W     = 4,
  parameter int PTR_W     = 8,
  parameter int ADDR_W    = 10,
  parameter int NUM_LANES = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic [ADDR_W-1:0]                   base_addr,
  input  logic [ROW_W:0]                      num_rows,
  input  logic [PTR_W*((2**ROW_W)+1)-1:0]     ptr_vec,
  output logic [PTR_W-1:0]                    nz_total,
  output logic                                busy,
  output logic                                done,
  csr_lane_dispatcher_if.master               bus
);

  localparam int MAX_ROWS = 2**ROW_W;
  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [ROW_W:0]  MAX_ROWS_V = (ROW_W+1)'(MAX_ROWS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    OUT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0]             base_q;
  logic [ROW_W:0]                rows_q;
  logic [ROW_W:0]                row;
  logic [PTR_W-1:0]              k;
  logic [LANE_W-1:0]             lane;
  logic [ROW_W+COL_W+DATA_W-1:0] data_q;

  logic [ROW_W:0]   rows_eff;
  logic [ROW_W:0]   row_end_idx;
  logic [PTR_W-1:0] ptr_start;
  logic [PTR_W-1:0] ptr_row_end;
  logic [PTR_W-1:0] k_inc;

  logic do_start;
  logic row_step;
  logic load_data;
  logic accept;

  // Pointer table lookups. Both indices are clamped to MAX_ROWS so that an
  // out-of-range num_rows or a saturated row counter never selects past the
  // end of ptr_vec.
  assign rows_eff    = (num_rows > MAX_ROWS_V) ? MAX_ROWS_V : num_rows;
  assign row_end_idx = (row >= MAX_ROWS_V) ? MAX_ROWS_V : row + 1'b1;
  assign ptr_start   = ptr_vec[int'(rows_eff) * PTR_W +: PTR_W];
  assign ptr_row_end = ptr_vec[int'(row_end_idx) * PTR_W +: PTR_W];
  assign k_inc       = k + 1'b1;

  assign bus.lane_data = data_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. Abort is tested first in every busy state
  // so it beats both the RAM read and a same-cycle handshake. In READ a row
  // boundary (k equals the end pointer of the current row) only advances the
  // row counter, which is what skips empty rows at one cycle each. The row
  // counter can only reach rows_q if ptr_vec is non-monotonic; treating that
  // as completion guarantees the walk always ends.
  always_comb begin
    state_next     = state;
    do_start       = 1'b0;
    row_step       = 1'b0;
    load_data      = 1'b0;
    accept         = 1'b0;
    bus.mem_ce     = 1'b0;
    bus.mem_addr   = '0;
    bus.lane_valid = '0;
    done           = 1'b0;
    busy           = (state != IDLE);

    case (state)
      IDLE: begin
        if (start && !abort) begin
          do_start   = 1'b1;
          state_next = (ptr_start == '0) ? DONE : READ;
        end
      end

      READ: begin
        if (abort) begin
          state_next = IDLE;
        end else if (row >= rows_q) begin
          state_next = DONE;
        end else if (k == ptr_row_end) begin
          row_step = 1'b1;
        end else begin
          bus.mem_ce   = 1'b1;
          bus.mem_addr = base_q + ADDR_W'(k);
          state_next   = WAIT;
        end
      end

      WAIT: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          load_data  = 1'b1;
          state_next = OUT;
        end
      end

      OUT: begin
        bus.lane_valid = NUM_LANES'(1) << lane;
        if (abort) begin
          state_next = IDLE;
        end else if (bus.lane_ready[lane]) begin
          accept     = 1'b1;
          state_next = (k_inc == nz_total) ? DONE : READ;
        end
      end

      DONE: begin
        done       = !abort;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Walk datapath: latched walk parameters, element/row/lane counters and
  // the output data register that stays stable through a stalled handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      rows_q   <= '0;
      nz_total <= '0;
      k        <= '0;
      row      <= '0;
      lane     <= '0;
      data_q   <= '0;
    end else begin
      if (do_start) begin
        base_q   <= base_addr;
        rows_q   <= rows_eff;
        nz_total <= ptr_start;
        k        <= '0;
        row      <= '0;
        lane     <= '0;
      end

      if (row_step) begin
        row <= row + 1'b1;
      end

      if (load_data) begin
        data_q <= {row[ROW_W-1:0], bus.mem_q};
      end

      if (accept) begin
        k    <= k_inc;
        lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
      end
    end
  end

endmodule
